// File: rtl/dbus_pkg.sv
// -----------------------------------------------------------------------------
// dbus_pkg
// Shared debug-bus (DMI) definitions used by the DMI arbiter and its neighbours.
//   - dmi_op_e   : DMI request opcode (NOP / READ / WRITE / RESERVED)
//   - dmi_resp_e : DMI response code (OK / RESERVED / ERR / BUSY)
//   - default widths for data, address and op/response-code fields
//   - helpers that assemble request/response words in the {.., op/code} layout
// No ports (package).
// -----------------------------------------------------------------------------
package dbus_pkg;

    localparam int DBUS_DEF_DATA_BITS = 32;
    localparam int DBUS_DEF_ADDR_BITS = 7;
    localparam int DBUS_DEF_OP_BITS   = 2;

    typedef enum logic [1:0] {
        DMI_OP_NOP      = 2'd0,
        DMI_OP_READ     = 2'd1,
        DMI_OP_WRITE    = 2'd2,
        DMI_OP_RESERVED = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        DMI_RESP_OK       = 2'd0,
        DMI_RESP_RESERVED = 2'd1,
        DMI_RESP_ERR      = 2'd2,
        DMI_RESP_BUSY     = 2'd3
    } dmi_resp_e;

    // Default-width request word: {addr, data, op}, op in the LSBs.
    function automatic logic [DBUS_DEF_ADDR_BITS+DBUS_DEF_DATA_BITS+DBUS_DEF_OP_BITS-1:0]
        dbus_pack_req(input logic [DBUS_DEF_ADDR_BITS-1:0] addr,
                      input logic [DBUS_DEF_DATA_BITS-1:0] data,
                      input dmi_op_e                       op);
        return {addr, data, op};
    endfunction

    // Default-width response word: {data, code}, code in the LSBs.
    function automatic logic [DBUS_DEF_DATA_BITS+DBUS_DEF_OP_BITS-1:0]
        dbus_pack_resp(input logic [DBUS_DEF_DATA_BITS-1:0] data,
                       input dmi_resp_e                     code);
        return {data, code};
    endfunction

endpackage

// File: rtl/dbus_arbiter.sv
// -----------------------------------------------------------------------------
// dbus_arbiter
// Two-port round-robin arbiter in front of the Debug Module's single DMI target.
// Port m0 is the JTAG DTM, port m1 the ICB-controlled DTM. One request is in
// flight at a time; the DM response is routed back to the port that issued it.
// A response timeout synthesizes an error response so a hung DM cannot lock out
// either DTM, and unsolicited DM responses are dropped and flagged.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   mX_req_valid/ready/bits       upstream request channels (X = 0, 1)
//   mX_resp_valid/ready/bits      upstream response channels
//   dm_req_valid/ready/bits       request channel to the DM
//   dm_resp_valid/ready/bits      response channel from the DM
//   sticky_clr                    clears timeout_flag and stray_flag
//   busy                          a transaction is in progress (state != IDLE)
//   owner                         port currently or most recently granted
//   timeout_flag                  sticky: a DM response timed out
//   stray_flag                    sticky: an unsolicited DM response was dropped
// -----------------------------------------------------------------------------
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int DEBUG_DATA_BITS = DBUS_DEF_DATA_BITS,
    parameter int DEBUG_ADDR_BITS = DBUS_DEF_ADDR_BITS,
    parameter int DEBUG_OP_BITS   = DBUS_DEF_OP_BITS,
    parameter int DBUS_REQ_BITS   = DEBUG_OP_BITS + DEBUG_ADDR_BITS + DEBUG_DATA_BITS,
    parameter int DBUS_RESP_BITS  = DEBUG_OP_BITS + DEBUG_DATA_BITS,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      m0_req_valid,
    output logic                      m0_req_ready,
    input  logic [DBUS_REQ_BITS-1:0]  m0_req_bits,
    output logic                      m0_resp_valid,
    input  logic                      m0_resp_ready,
    output logic [DBUS_RESP_BITS-1:0] m0_resp_bits,

    input  logic                      m1_req_valid,
    output logic                      m1_req_ready,
    input  logic [DBUS_REQ_BITS-1:0]  m1_req_bits,
    output logic                      m1_resp_valid,
    input  logic                      m1_resp_ready,
    output logic [DBUS_RESP_BITS-1:0] m1_resp_bits,

    output logic                      dm_req_valid,
    input  logic                      dm_req_ready,
    output logic [DBUS_REQ_BITS-1:0]  dm_req_bits,
    input  logic                      dm_resp_valid,
    output logic                      dm_resp_ready,
    input  logic [DBUS_RESP_BITS-1:0] dm_resp_bits,

    input  logic                      sticky_clr,
    output logic                      busy,
    output logic                      owner,
    output logic                      timeout_flag,
    output logic                      stray_flag
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DLV  = 2'd3
    } state_e;

    // Counter wide enough to reach TIMEOUT_CYCLES; one bit when the timeout is off.
    localparam int                CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic              TIMEOUT_EN = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;

    // Synthesized response on timeout: data 0, code ERR.
    localparam logic [DBUS_RESP_BITS-1:0] RESP_TIMEOUT =
        DBUS_RESP_BITS'({{DEBUG_DATA_BITS{1'b0}}, DEBUG_OP_BITS'(DMI_RESP_ERR)});

    state_e                    state_q, state_d;
    logic                      owner_q, owner_d;
    logic [DBUS_REQ_BITS-1:0]  req_q, req_d;
    logic [DBUS_RESP_BITS-1:0] rsp_q, rsp_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      timeout_flag_q, timeout_flag_d;
    logic                      stray_flag_q, stray_flag_d;
    logic                      dm_resp_ready_q, dm_resp_ready_d;

    logic                      grant_m0_s;
    logic                      grant_m1_s;
    logic                      owner_resp_ready_s;
    logic                      timeout_set_s;
    logic                      stray_set_s;

    // Round-robin: on a tie the port that is not the current owner wins.
    always_comb begin
        grant_m0_s = m0_req_valid & (~m1_req_valid | owner_q);
        grant_m1_s = m1_req_valid & (~m0_req_valid | ~owner_q);
    end

    // Response-ready of whichever port owns the transaction being delivered.
    always_comb begin
        if (owner_q) begin
            owner_resp_ready_s = m1_resp_ready;
        end else begin
            owner_resp_ready_s = m0_resp_ready;
        end
    end

    // Next-state, datapath capture and handshake decode.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        req_d         = req_q;
        rsp_d         = rsp_q;
        cnt_d         = cnt_q;
        timeout_set_s = 1'b0;
        stray_set_s   = 1'b0;
        m0_req_ready  = 1'b0;
        m1_req_ready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_m0_s) begin
                    m0_req_ready = 1'b1;
                    req_d        = m0_req_bits;
                    owner_d      = 1'b0;
                    state_d      = ST_REQ;
                end else if (grant_m1_s) begin
                    m1_req_ready = 1'b1;
                    req_d        = m1_req_bits;
                    owner_d      = 1'b1;
                    state_d      = ST_REQ;
                end else begin
                    state_d      = ST_IDLE;
                end
                // Nothing is outstanding, so any response here is unsolicited.
                stray_set_s = dm_resp_valid & dm_resp_ready_q;
            end

            ST_REQ: begin
                if (dm_req_ready) begin
                    if (dm_resp_valid && dm_resp_ready_q) begin
                        // DM answered in the accept cycle: skip RSP.
                        rsp_d   = dm_resp_bits;
                        state_d = ST_DLV;
                    end else begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_RSP;
                    end
                end else begin
                    // Response before the request is taken belongs to an
                    // earlier (timed-out) transaction.
                    stray_set_s = dm_resp_valid & dm_resp_ready_q;
                end
            end

            ST_RSP: begin
                if (dm_resp_valid) begin
                    rsp_d   = dm_resp_bits;
                    state_d = ST_DLV;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LIMIT)) begin
                    rsp_d         = RESP_TIMEOUT;
                    timeout_set_s = 1'b1;
                    state_d       = ST_DLV;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DLV: begin
                if (owner_resp_ready_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DLV;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky flags: a set event in the same cycle beats sticky_clr.
    always_comb begin
        if (timeout_set_s) begin
            timeout_flag_d = 1'b1;
        end else if (sticky_clr) begin
            timeout_flag_d = 1'b0;
        end else begin
            timeout_flag_d = timeout_flag_q;
        end

        if (stray_set_s) begin
            stray_flag_d = 1'b1;
        end else if (sticky_clr) begin
            stray_flag_d = 1'b0;
        end else begin
            stray_flag_d = stray_flag_q;
        end
    end

    // DM response is accepted in every state except DLV, where rsp_q is
    // still held for the upstream port. Registered so it is low in reset.
    always_comb begin
        dm_resp_ready_d = (state_d != ST_DLV) ? 1'b1 : 1'b0;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            owner_q         <= 1'b1;
            req_q           <= {DBUS_REQ_BITS{1'b0}};
            rsp_q           <= {DBUS_RESP_BITS{1'b0}};
            cnt_q           <= {CNT_W{1'b0}};
            timeout_flag_q  <= 1'b0;
            stray_flag_q    <= 1'b0;
            dm_resp_ready_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            req_q           <= req_d;
            rsp_q           <= rsp_d;
            cnt_q           <= cnt_d;
            timeout_flag_q  <= timeout_flag_d;
            stray_flag_q    <= stray_flag_d;
            dm_resp_ready_q <= dm_resp_ready_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        busy          = (state_q != ST_IDLE) ? 1'b1 : 1'b0;
        owner         = owner_q;
        timeout_flag  = timeout_flag_q;
        stray_flag    = stray_flag_q;
        dm_resp_ready = dm_resp_ready_q;
        dm_req_valid  = (state_q == ST_REQ) ? 1'b1 : 1'b0;
        dm_req_bits   = req_q;
        m0_resp_valid = ((state_q == ST_DLV) && !owner_q) ? 1'b1 : 1'b0;
        m1_resp_valid = ((state_q == ST_DLV) &&  owner_q) ? 1'b1 : 1'b0;
        // Only the owning port sees the response payload.
        m0_resp_bits  = owner_q ? {DBUS_RESP_BITS{1'b0}} : rsp_q;
        m1_resp_bits  = owner_q ? rsp_q : {DBUS_RESP_BITS{1'b0}};
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dbus_arbiter
// Directed testbench for dbus_arbiter (TIMEOUT_CYCLES = 4). Inputs change and
// outputs are sampled on the falling clock edge; the DUT acts on the rising one.
// -----------------------------------------------------------------------------
module tb_dbus_arbiter;
    import dbus_pkg::*;

    localparam int RQ = 41;
    localparam int RS = 34;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
    logic          m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
    logic [RQ-1:0] m0_req_bits, m1_req_bits, dm_req_bits;
    logic [RS-1:0] m0_resp_bits, m1_resp_bits, dm_resp_bits;
    logic          dm_req_valid, dm_req_ready, dm_resp_valid, dm_resp_ready;
    logic          sticky_clr, busy, owner, timeout_flag, stray_flag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dbus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_bits(m0_req_bits),
        .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp_bits(m0_resp_bits),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_bits(m1_req_bits),
        .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp_bits(m1_resp_bits),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_bits(dm_req_bits),
        .dm_resp_valid(dm_resp_valid), .dm_resp_ready(dm_resp_ready), .dm_resp_bits(dm_resp_bits),
        .sticky_clr(sticky_clr), .busy(busy), .owner(owner),
        .timeout_flag(timeout_flag), .stray_flag(stray_flag)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // From the falling edge right after a grant: fast-path DM answer, then
    // delivery to port 'port' and upstream accept; ends on an IDLE falling edge.
    task automatic serve(input string tag, input logic port, input logic [RQ-1:0] exp_req,
                         input logic [RS-1:0] rsp);
        @(negedge clk);
        chk({tag, ".dm_req_valid"}, dm_req_valid, 1'b1);
        chk({tag, ".dm_req_bits"}, dm_req_bits, exp_req);
        chk({tag, ".owner"}, owner, port);
        chk({tag, ".no_ready_in_req"}, {m0_req_ready, m1_req_ready}, 2'b00);
        dm_req_ready = 1'b1; dm_resp_valid = 1'b1; dm_resp_bits = rsp;
        @(negedge clk);
        dm_req_ready = 1'b0; dm_resp_valid = 1'b0;
        chk({tag, ".resp_valid"}, {m1_resp_valid, m0_resp_valid}, port ? 2'b10 : 2'b01);
        chk({tag, ".resp_bits"}, port ? m1_resp_bits : m0_resp_bits, rsp);
        chk({tag, ".dm_resp_ready_dlv"}, dm_resp_ready, 1'b0);
        chk({tag, ".no_ready_in_dlv"}, {m0_req_ready, m1_req_ready}, 2'b00);
        if (port) m1_resp_ready = 1'b1; else m0_resp_ready = 1'b1;
        @(negedge clk);
        m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
        chk({tag, ".busy_after"}, busy, 1'b0);
        chk({tag, ".resp_valid_after"}, {m1_resp_valid, m0_resp_valid}, 2'b00);
    endtask

    logic [RQ-1:0] ra, rb, rc, rd;

    initial begin
        rst = 1'b1;
        m0_req_valid = 1'b0; m0_req_bits = '0; m0_resp_ready = 1'b0;
        m1_req_valid = 1'b0; m1_req_bits = '0; m1_resp_ready = 1'b0;
        dm_req_ready = 1'b0; dm_resp_valid = 1'b0; dm_resp_bits = '0;
        sticky_clr = 1'b0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.owner", owner, 1'b1);
        chk("rst.valids", {dm_req_valid, m0_resp_valid, m1_resp_valid}, 3'b000);
        chk("rst.flags", {timeout_flag, stray_flag}, 2'b00);
        chk("rst.dm_resp_ready", dm_resp_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // ---- single request, DM answers one cycle after ready ----
        ra = dbus_pack_req(7'h11, 32'h0, DMI_OP_READ);
        m0_req_valid = 1'b1; m0_req_bits = ra;
        #1;
        chk("single.m0_ready", m0_req_ready, 1'b1);
        chk("single.m1_ready", m1_req_ready, 1'b0);
        @(negedge clk);
        m0_req_valid = 1'b0;
        chk("single.dm_req_valid", dm_req_valid, 1'b1);
        chk("single.dm_req_bits", dm_req_bits, ra);
        chk("single.owner", owner, 1'b0);
        chk("single.busy", busy, 1'b1);
        dm_req_ready = 1'b1;
        @(negedge clk);
        dm_req_ready = 1'b0;
        chk("single.rsp_state", {dm_req_valid, dm_resp_ready, m0_resp_valid}, 3'b010);
        dm_resp_valid = 1'b1; dm_resp_bits = dbus_pack_resp(32'hDEADBEEF, DMI_RESP_OK);
        @(negedge clk);
        dm_resp_valid = 1'b0;
        chk("single.m0_resp_valid", m0_resp_valid, 1'b1);
        chk("single.m0_resp_bits", m0_resp_bits, 34'h3_7AB6_FBBC);
        chk("single.m1_resp_valid", m1_resp_valid, 1'b0);
        chk("single.busy_dlv", busy, 1'b1);
        m0_resp_ready = 1'b1;
        @(negedge clk);
        m0_resp_ready = 1'b0;
        chk("single.busy_after", busy, 1'b0);
        chk("single.owner_after", owner, 1'b0);

        // ---- simultaneous requests after reset ----
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ra = dbus_pack_req(7'h10, 32'h0, DMI_OP_READ);
        rb = dbus_pack_req(7'h04, 32'h1234_5678, DMI_OP_WRITE);
        m0_req_valid = 1'b1; m0_req_bits = ra;
        m1_req_valid = 1'b1; m1_req_bits = rb;
        #1;
        chk("tie1.ready", {m1_req_ready, m0_req_ready}, 2'b01);
        @(posedge clk);
        #1 m0_req_valid = 1'b0;
        serve("tie1.m0", 1'b0, ra, dbus_pack_resp(32'h0000_00A5, DMI_RESP_OK));
        #1;
        chk("tie1.m1_ready_idle", m1_req_ready, 1'b1);
        @(posedge clk);
        #1 m1_req_valid = 1'b0;
        serve("tie1.m1", 1'b1, rb, dbus_pack_resp(32'h0, DMI_RESP_BUSY));

        // second tie: owner is 1, so m0 wins again
        rc = dbus_pack_req(7'h7F, 32'hFFFF_FFFF, DMI_OP_WRITE);
        rd = dbus_pack_req(7'h01, 32'h0, DMI_OP_NOP);
        m0_req_valid = 1'b1; m0_req_bits = rc;
        m1_req_valid = 1'b1; m1_req_bits = rd;
        #1;
        chk("tie2.ready", {m1_req_ready, m0_req_ready}, 2'b01);
        @(posedge clk);
        #1 m0_req_valid = 1'b0;
        serve("tie2.m0", 1'b0, rc, dbus_pack_resp(32'hCAFE_F00D, DMI_RESP_OK));
        #1;
        chk("tie2.m1_ready_idle", m1_req_ready, 1'b1);
        @(posedge clk);
        #1 m1_req_valid = 1'b0;
        serve("tie2.m1", 1'b1, rd, dbus_pack_resp(32'h8000_0001, DMI_RESP_ERR));

        // ---- timeout: DM accepts but never answers ----
        ra = dbus_pack_req(7'h22, 32'h0, DMI_OP_READ);
        m0_req_valid = 1'b1; m0_req_bits = ra;
        @(negedge clk);
        m0_req_valid = 1'b0;
        dm_req_ready = 1'b1;
        @(negedge clk);            // first RSP cycle
        dm_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("to.wait%0d", k), {m0_resp_valid, timeout_flag}, 2'b00);
            @(negedge clk);
        end
        chk("to.resp_valid", m0_resp_valid, 1'b1);
        chk("to.resp_bits", m0_resp_bits, 34'h0_0000_0002);
        chk("to.flag", timeout_flag, 1'b1);
        m0_resp_ready = 1'b1;
        @(negedge clk);
        m0_resp_ready = 1'b0;
        chk("to.busy_after", busy, 1'b0);

        // ---- late response in IDLE is dropped ----
        chk("late.dm_resp_ready", dm_resp_ready, 1'b1);
        dm_resp_valid = 1'b1; dm_resp_bits = dbus_pack_resp(32'h5555_5555, DMI_RESP_OK);
        @(negedge clk);
        dm_resp_valid = 1'b0;
        chk("late.stray", stray_flag, 1'b1);
        chk("late.no_resp", {m0_resp_valid, m1_resp_valid, busy}, 3'b000);
        // set beats clear in the same cycle
        dm_resp_valid = 1'b1; sticky_clr = 1'b1;
        @(negedge clk);
        dm_resp_valid = 1'b0;
        chk("late.set_wins", {timeout_flag, stray_flag}, 2'b01);
        @(negedge clk);
        sticky_clr = 1'b0;
        chk("late.cleared", {timeout_flag, stray_flag}, 2'b00);

        // ---- reset while in RSP ----
        m0_req_valid = 1'b1; m0_req_bits = ra;
        @(negedge clk);
        m0_req_valid = 1'b0;
        dm_req_ready = 1'b1;
        @(negedge clk);
        dm_req_ready = 1'b0;
        chk("rrsp.in_rsp", {busy, owner, dm_resp_ready}, 3'b101);
        rst = 1'b1;
        #1;
        chk("rrsp.valids", {dm_req_valid, m0_resp_valid, m1_resp_valid}, 3'b000);
        chk("rrsp.state", {busy, owner}, 2'b01);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rrsp.quiet%0d", k), {m0_resp_valid, m1_resp_valid, busy}, 3'b000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
